mio_arbiter: RTL
================

Name: mio_arbiter

Overview:
- Shares the single core memory port (mio_*) between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Allows one outstanding transaction at a time.
- Data requests have fixed priority over fetch, with a starvation guard so fetch always makes progress.
- Responses are registered and returned to the granted requester as a one-cycle valid pulse.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while ireq is pending before fetch is forced to win (range 1..15).
- TIMEOUT, 255, BUSY cycles without mio_vld before the transaction is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  reset; synchronous, active-high.
- ireq  in  1  fetch request; held with iaddr until ivld.
- iaddr  in  32  fetch address (word aligned).
- ikill  in  1  discard the in-flight fetch response (redirect).
- ivld  out  1  fetch response pulse.
- irdata  out  32  fetch read data.
- dreq  in  1  data request; held with dwe/daddr/dwdata/dwmask until dvld.
- dwe  in  1  1 = store, 0 = load.
- daddr  in  32  data address.
- dwdata  in  32  store data.
- dwmask  in  4  byte write enables.
- dvld  out  1  data response pulse (loads and stores).
- drdata  out  32  load data.
- mio_req  out  1  memory request, held until mio_vld.
- mio_rw  out  1  1 = write.
- mio_addr  out  32  memory address.
- mio_wdata  out  32  memory write data.
- mio_wmask  out  4  memory byte enables (0000 on reads).
- mio_vld  in  1  memory completion.
- mio_rdata  in  32  memory read data, valid with mio_vld.
- err  out  1  timeout pulse, coincident with the aborted response.

Behaviour:
- Reset (clr):
  - state = IDLE.
  - All outputs are 0, including mio_addr, mio_wdata, irdata and drdata.
  - starve_cnt = 0 and tmo_cnt = 0.
  - clr asserted mid-transaction aborts it: no vld pulse is issued, and a late mio_vld is ignored in IDLE.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE arbitration:
  - dreq && !(ireq && starve_cnt == STARVE_LIMIT) -> grant data, go to BUSY_D.
  - else if ireq -> grant fetch, go to BUSY_I.
  - else stay in IDLE.
- Grant:
  - The mio_* outputs are registered from the winner's inputs on the grant edge.
  - mio_req = 1 from the first BUSY cycle. mio_* are stable for the whole of BUSY.
  - Fetch grants drive mio_rw = 0 and mio_wmask = 0000.
- starve_cnt:
  - Increments (saturating at 15) on a data grant while ireq = 1.
  - Clears on a fetch grant, or on a data grant while ireq = 0.
- BUSY_x:
  - tmo_cnt increments each cycle.
  - On mio_vld: capture mio_rdata, drop mio_req, go to RESP_x. tmo_cnt clears.
  - On TIMEOUT != 0 && tmo_cnt == TIMEOUT-1 without mio_vld: drop mio_req, go to RESP_x with captured data = 0, and set the error flag.
- RESP_x:
  - Exactly one cycle, then back to IDLE.
  - The requester sees the vld pulse in RESP and updates its req by the next edge, so the stale request is never re-granted.
  - RESP_I: ivld = 1 and irdata = captured data, unless ikill was seen at any cycle of BUSY_I or RESP_I. In that case ivld stays 0 and irdata is unchanged.
  - RESP_D: dvld = 1. drdata = captured data for loads; drdata is unchanged for stores.
  - err = 1 in RESP if the timeout flag is set; the flag then clears.
- Latency:
  - Grant to mio_req is 1 cycle.
  - mio_vld to ivld/dvld is 1 cycle.
  - Minimum issue spacing is mio latency + 3 cycles.
- Simultaneous events:
  - ireq and dreq in the same IDLE cycle follow the priority rule above.
  - mio_vld on the timeout cycle counts as a normal completion, with err = 0.
- ivld, dvld and err are never asserted in the same cycle as each other's state, and never outside RESP.

Decomposition:
- Shared package mio_pkg:
  - State encoding constants.
  - Width constants: XLEN = 32, MASK_W = 4.
  - Response-kind constants (fetch/data).
- Sub-module mio_arb_prio:
  - Combinational winner select plus the starve_cnt register.
  - Instantiated once.
- The FSM, timeout counter and registers stay in the top level.

Test Plan:
- Fetch only:
  - Stimulus: ireq = 1, iaddr = 0x10; memory returns mio_vld 2 cycles after mio_req with rdata = 0x00000013.
  - Required: mio_addr = 0x10, mio_rw = 0, ivld pulses once with irdata = 0x13, err = 0.
- Priority:
  - Stimulus: ireq and dreq rise together; dwe = 1, daddr = 0x200, dwdata = 0xDEADBEEF, dwmask = 1111.
  - Required: the store is granted first (mio_rw = 1, mio_wmask = 1111); dvld pulses; then the fetch is granted.
- Starvation:
  - Stimulus: dreq held continuously (new address after each dvld) with ireq = 1 and STARVE_LIMIT = 4.
  - Required: 4 data grants, then 1 fetch grant, then data grants resume.
- Kill:
  - Stimulus: fetch of 0x14 in flight; ikill pulses in BUSY_I.
  - Required: mio completes, ivld stays 0, next IDLE cycle is back in arbitration, irdata is unchanged.
- Timeout:
  - Stimulus: TIMEOUT = 8, mio_vld is never returned for a load of 0x300.
  - Required: mio_req drops after 8 BUSY cycles; dvld = 1, drdata = 0 and err = 1 in the same cycle.
- Reset mid-transaction:
  - Stimulus: clr asserted in BUSY_D, then mio_vld arrives a cycle later.
  - Required: all outputs are 0, no dvld pulse, state is IDLE, starve_cnt = 0.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared constants for the memory-port arbiter: state encoding, bus widths and response kinds.
package mio_pkg;

  localparam int XLEN     = 32;
  localparam int MASK_W   = 4;
  localparam int STATE_W  = 3;
  localparam int STARVE_W = 4;

  localparam logic [STARVE_W-1:0] STARVE_MAX = 4'hF;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_BUSY_I = 3'd1;
  localparam logic [STATE_W-1:0] ST_BUSY_D = 3'd2;
  localparam logic [STATE_W-1:0] ST_RESP_I = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP_D = 3'd4;

  localparam logic KIND_FETCH = 1'b0;
  localparam logic KIND_DATA  = 1'b1;

  function automatic logic [STATE_W-1:0] kind_to_busy(input logic kind);
    return (kind == KIND_DATA) ? ST_BUSY_D : ST_BUSY_I;
  endfunction

  function automatic logic [STATE_W-1:0] busy_to_resp(input logic [STATE_W-1:0] st);
    return (st == ST_BUSY_D) ? ST_RESP_D : ST_RESP_I;
  endfunction

endpackage

// File: rtl/mio_arbiter_if.sv
// Fetch, data and memory-side signal bundle around mio_arbiter; master is the arbiter's view.
interface mio_arbiter_if;
  import mio_pkg::*;

  logic              ireq;
  logic [XLEN-1:0]   iaddr;
  logic              ikill;
  logic              ivld;
  logic [XLEN-1:0]   irdata;

  logic              dreq;
  logic              dwe;
  logic [XLEN-1:0]   daddr;
  logic [XLEN-1:0]   dwdata;
  logic [MASK_W-1:0] dwmask;
  logic              dvld;
  logic [XLEN-1:0]   drdata;

  logic              mio_req;
  logic              mio_rw;
  logic [XLEN-1:0]   mio_addr;
  logic [XLEN-1:0]   mio_wdata;
  logic [MASK_W-1:0] mio_wmask;
  logic              mio_vld;
  logic [XLEN-1:0]   mio_rdata;

  logic              err;

  modport master (
    input  ireq, iaddr, ikill,
    input  dreq, dwe, daddr, dwdata, dwmask,
    input  mio_vld, mio_rdata,
    output ivld, irdata, dvld, drdata,
    output mio_req, mio_rw, mio_addr, mio_wdata, mio_wmask,
    output err
  );

  modport slave (
    output ireq, iaddr, ikill,
    output dreq, dwe, daddr, dwdata, dwmask,
    output mio_vld, mio_rdata,
    input  ivld, irdata, dvld, drdata,
    input  mio_req, mio_rw, mio_addr, mio_wdata, mio_wmask,
    input  err
  );

endinterface

// File: rtl/mio_arb_prio.sv
// Winner select for the memory port: data first unless fetch has lost STARVE_LIMIT grants in a row.
// Combinational grant, registered starvation counter updated only on grant edges.
module mio_arb_prio
  import mio_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic arb_en,
  input  logic ireq,
  input  logic dreq,
  output logic grant_vld,
  output logic grant_kind
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                force_fetch;
  logic                take_data;

  assign force_fetch = ireq && (starve_cnt == LIMIT);
  assign take_data   = dreq && !force_fetch;
  assign grant_vld   = arb_en && (take_data || ireq);
  assign grant_kind  = take_data ? KIND_DATA : KIND_FETCH;

  // Only data wins that actually made fetch wait count towards starvation.
  always_ff @(posedge clk) begin
    if (clr) begin
      starve_cnt <= '0;
    end else if (grant_vld) begin
      if ((grant_kind == KIND_DATA) && ireq) begin
        if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Shares the core memory port between fetch and data, one transaction at a time; grant->mio_req and
// mio_vld->ivld/dvld are 1 cycle each; requesters hold req until their vld pulse, mio_req held until mio_vld.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic           clk,
  input logic           clr,
  mio_arbiter_if.master bus
);

  localparam int               TMO_W    = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_flag;
  logic               kill_seen;
  logic [XLEN-1:0]    cap_q;
  logic [XLEN-1:0]    irdata_q;
  logic [XLEN-1:0]    drdata_q;

  logic               mio_req_q;
  logic               mio_rw_q;
  logic [XLEN-1:0]    mio_addr_q;
  logic [XLEN-1:0]    mio_wdata_q;
  logic [MASK_W-1:0]  mio_wmask_q;

  logic               arb_en;
  logic               grant_vld;
  logic               grant_kind;
  logic               tmo_hit;
  logic               in_resp;
  logic               ivld_c;
  logic               dvld_c;

  assign arb_en = (state == ST_IDLE);

  mio_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .clr        (clr),
    .arb_en     (arb_en),
    .ireq       (bus.ireq),
    .dreq       (bus.dreq),
    .grant_vld  (grant_vld),
    .grant_kind (grant_kind)
  );

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign in_resp = (state == ST_RESP_I) || (state == ST_RESP_D);

  // A redirect arriving in the response cycle itself still suppresses the pulse.
  assign ivld_c = (state == ST_RESP_I) && !kill_seen && !bus.ikill;
  assign dvld_c = (state == ST_RESP_D);

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
      kill_seen   <= 1'b0;
      cap_q       <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      mio_req_q   <= 1'b0;
      mio_rw_q    <= 1'b0;
      mio_addr_q  <= '0;
      mio_wdata_q <= '0;
      mio_wmask_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt   <= '0;
          tmo_flag  <= 1'b0;
          kill_seen <= 1'b0;
          if (grant_vld) begin
            state     <= kind_to_busy(grant_kind);
            mio_req_q <= 1'b1;
            if (grant_kind == KIND_DATA) begin
              mio_rw_q    <= bus.dwe;
              mio_addr_q  <= bus.daddr;
              mio_wdata_q <= bus.dwe ? bus.dwdata : '0;
              mio_wmask_q <= bus.dwe ? bus.dwmask : '0;
            end else begin
              mio_rw_q    <= 1'b0;
              mio_addr_q  <= bus.iaddr;
              mio_wdata_q <= '0;
              mio_wmask_q <= '0;
            end
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if ((state == ST_BUSY_I) && bus.ikill) begin
            kill_seen <= 1'b1;
          end
          // Completion beats the timeout when both land on the same cycle.
          if (bus.mio_vld) begin
            cap_q     <= bus.mio_rdata;
            mio_req_q <= 1'b0;
            tmo_cnt   <= '0;
            state     <= busy_to_resp(state);
          end else if (tmo_hit) begin
            cap_q     <= '0;
            mio_req_q <= 1'b0;
            tmo_cnt   <= '0;
            tmo_flag  <= 1'b1;
            state     <= busy_to_resp(state);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RESP_I: begin
          if (ivld_c) begin
            irdata_q <= cap_q;
          end
          tmo_flag  <= 1'b0;
          kill_seen <= 1'b0;
          state     <= ST_IDLE;
        end

        ST_RESP_D: begin
          if (!mio_rw_q) begin
            drdata_q <= cap_q;
          end
          tmo_flag <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data is presented straight from the capture register during the pulse, then held.
  assign bus.ivld      = ivld_c;
  assign bus.irdata    = ivld_c ? cap_q : irdata_q;
  assign bus.dvld      = dvld_c;
  assign bus.drdata    = (dvld_c && !mio_rw_q) ? cap_q : drdata_q;
  assign bus.err       = in_resp && tmo_flag;

  assign bus.mio_req   = mio_req_q;
  assign bus.mio_rw    = mio_rw_q;
  assign bus.mio_addr  = mio_addr_q;
  assign bus.mio_wdata = mio_wdata_q;
  assign bus.mio_wmask = mio_wmask_q;

endmodule
